// File: rtl/fmt_pkg.sv
// Shared types, ASCII constants and BCD helper functions for the stream ASCII formatter.
package fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_TAG     = 3'd2,
        ST_DIGITS  = 3'd3,
        ST_CR      = 3'd4,
        ST_LF      = 3'd5
    } fmt_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         BCD_DIGITS = 10;

    // Double-dabble correction: add 3 to every nibble that is 5 or more before shifting.
    function automatic logic [39:0] bcd_adjust(input logic [39:0] bcd);
        logic [39:0] res;
        res = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? (bcd[i*4 +: 4] + 4'd3) : bcd[i*4 +: 4];
        end
        return res;
    endfunction

    // Index of the most significant non-zero digit; 0 when the whole value is zero.
    function automatic logic [3:0] top_digit_idx(input logic [39:0] bcd);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            idx = (bcd[i*4 +: 4] != 4'd0) ? 4'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [39:0] bcd, input logic [3:0] idx);
        return ASCII_ZERO + {4'd0, bcd[{idx, 2'b00} +: 4]};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 10-digit BCD converter, one double-dabble step per clock.
module bin2bcd_seq
    import fmt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        done,
    output logic [39:0] bcd
);

    logic [39:0] bcd_r;
    logic [31:0] bin_r;
    logic [4:0]  cnt_r;
    logic        run_r;
    logic        done_r;
    logic [39:0] adj_s;

    // Nibble correction ahead of the shift.
    always_comb begin
        adj_s = bcd_adjust(bcd_r);
    end

    // Shift register and bit counter; done pulses on the edge of the 32nd shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_r  <= 40'd0;
            bin_r  <= 32'd0;
            cnt_r  <= 5'd0;
            run_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            bcd_r  <= 40'd0;
            bin_r  <= bin;
            cnt_r  <= 5'd0;
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else if (run_r) begin
            {bcd_r, bin_r} <= {adj_s[38:0], bin_r, 1'b0};
            cnt_r  <= cnt_r + 5'd1;
            run_r  <= (cnt_r != 5'd31);
            done_r <= (cnt_r == 5'd31);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/stream_ascii_formatter.sv
// Renders 32-bit stream samples as ASCII decimal lines (tag, digits, CR, LF), one byte per beat.
// Define ASCII_ZERO_SUPPRESS_EN to drop leading zero digits (at least one digit is always sent).
module stream_ascii_formatter
    import fmt_pkg::*;
#(
    parameter bit         TAG_EN   = 1'b1,
    parameter logic [7:0] TAG_CHAR = 8'h54
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        busy
);

    fmt_state_t  state_r, state_nx_s;
    logic [3:0]  digit_r, digit_nx_s;
    logic        tvalid_r, tvalid_nx_s;
    logic [7:0]  tdata_r, tdata_nx_s;
    logic        sready_r;
    logic        busy_r;
    logic        start_s;
    logic        done_s;
    logic [39:0] bcd_s;
    logic [3:0]  first_digit_s;
    logic [7:0]  byte_s;

    assign start_s = s_axis_tvalid & sready_r;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .bin   (s_axis_tdata),
        .done  (done_s),
        .bcd   (bcd_s)
    );

`ifdef ASCII_ZERO_SUPPRESS_EN
    assign first_digit_s = top_digit_idx(bcd_s);
`else
    assign first_digit_s = 4'd9;
`endif

    // Byte presented for the current output state once the previous beat has drained.
    always_comb begin
        byte_s = 8'h00;
        case (state_r)
            ST_TAG:    byte_s = TAG_CHAR;
            ST_DIGITS: byte_s = digit_ascii(bcd_s, digit_r);
            ST_CR:     byte_s = ASCII_CR;
            ST_LF:     byte_s = ASCII_LF;
            default:   byte_s = 8'h00;
        endcase
    end

    // Next-state and next-output logic; a beat always drops valid for one cycle.
    always_comb begin
        state_nx_s  = state_r;
        digit_nx_s  = digit_r;
        tvalid_nx_s = tvalid_r;
        tdata_nx_s  = tdata_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nx_s = ST_CONVERT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CONVERT: begin
                if (done_s) begin
                    tvalid_nx_s = 1'b1;
                    digit_nx_s  = first_digit_s;
                    if (TAG_EN) begin
                        state_nx_s = ST_TAG;
                        tdata_nx_s = TAG_CHAR;
                    end else begin
                        state_nx_s = ST_DIGITS;
                        tdata_nx_s = digit_ascii(bcd_s, first_digit_s);
                    end
                end else begin
                    state_nx_s = ST_CONVERT;
                end
            end
            ST_TAG, ST_DIGITS, ST_CR, ST_LF: begin
                if (tvalid_r && m_axis_tready) begin
                    tvalid_nx_s = 1'b0;
                    case (state_r)
                        ST_TAG:    state_nx_s = ST_DIGITS;
                        ST_DIGITS: begin
                            if (digit_r == 4'd0) begin
                                state_nx_s = ST_CR;
                            end else begin
                                digit_nx_s = digit_r - 4'd1;
                            end
                        end
                        ST_CR:     state_nx_s = ST_LF;
                        default:   state_nx_s = ST_IDLE;
                    endcase
                end else if (!tvalid_r) begin
                    tvalid_nx_s = 1'b1;
                    tdata_nx_s  = byte_s;
                end else begin
                    tvalid_nx_s = 1'b1;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                tvalid_nx_s = 1'b0;
            end
        endcase
    end

    // State and output registers; ready/busy are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            digit_r  <= 4'd0;
            tvalid_r <= 1'b0;
            tdata_r  <= 8'h00;
            sready_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            digit_r  <= digit_nx_s;
            tvalid_r <= tvalid_nx_s;
            tdata_r  <= tdata_nx_s;
            sready_r <= (state_nx_s == ST_IDLE);
            busy_r   <= (state_nx_s != ST_IDLE);
        end
    end

    assign s_axis_tready = sready_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign busy          = busy_r;

endmodule
